// File: rtl/move_sequencer_pkg.sv
// Shared types and constants for the register-to-register move sequencer.
package move_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_IMM  = 2'b00;
  localparam logic [1:0] MODE_COPY = 2'b10;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/move_decode.sv
// Combinational instruction decode: mode flags, one-hot slot selects, immediate.
module move_decode
  import move_sequencer_pkg::*;
(
  input  logic [7:0] instr,
  output logic       is_copy,
  output logic       is_imm,
  output logic       is_bad,
  output logic [7:0] src_oh,
  output logic [7:0] dst_oh,
  output logic [5:0] imm6
);

  assign is_copy = (instr[7:6] == MODE_COPY);
  assign is_imm  = (instr[7:6] == MODE_IMM);
  assign is_bad  = !(is_copy || is_imm);
  assign src_oh  = onehot8(instr[5:3]);
  assign dst_oh  = onehot8(instr[2:0]);
  assign imm6    = instr[5:0];

endmodule

// File: rtl/move_sequencer.sv
// Moves a byte between register slots (copy) or loads an immediate into slot 0,
// driving only the slots' read/write enables and shared input port.
//
// state | meaning
// IDLE  | ready for an instruction; rejected modes pulse bad_op
// READ  | rd_en selects source slot; bus_rd captured at end of cycle
// WRITE | wr_en selects destination slot with wr_data; move_count bumps on exit
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int UUID = 0,
  parameter     NAME = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] bus_rd,
  output logic [7:0] rd_en,
  output logic [7:0] wr_en,
  output logic [7:0] wr_data,
  output logic       bad_op,
  output logic [7:0] move_count
);

  state_e     state_q;
  logic [7:0] rd_en_q;
  logic [7:0] wr_en_q;
  logic [7:0] wr_data_q;
  logic [7:0] dst_oh_q;
  logic       bad_op_q;
  logic [7:0] move_count_q;

  logic       dec_copy;
  logic       dec_imm;
  logic       dec_bad;
  logic [7:0] dec_src_oh;
  logic [7:0] dec_dst_oh;
  logic [5:0] dec_imm6;

  // Identity parameters carry no function in this block.
  logic unused_id;
  assign unused_id = ^{UUID[31:0], (NAME == "")};

  move_decode u_decode (
    .instr   (instr),
    .is_copy (dec_copy),
    .is_imm  (dec_imm),
    .is_bad  (dec_bad),
    .src_oh  (dec_src_oh),
    .dst_oh  (dec_dst_oh),
    .imm6    (dec_imm6)
  );

  // wr_data_q doubles as the data latch: it holds bus_rd from READ through WRITE and beyond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rd_en_q      <= 8'h00;
      wr_en_q      <= 8'h00;
      wr_data_q    <= 8'h00;
      dst_oh_q     <= 8'h00;
      bad_op_q     <= 1'b0;
      move_count_q <= 8'h00;
    end else begin
      bad_op_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            if (dec_copy) begin
              state_q  <= READ;
              rd_en_q  <= dec_src_oh;
              dst_oh_q <= dec_dst_oh;
            end else if (dec_imm) begin
              state_q   <= WRITE;
              wr_en_q   <= 8'h01;
              wr_data_q <= {2'b00, dec_imm6};
            end else if (dec_bad) begin
              bad_op_q <= 1'b1;
            end
          end
        end
        READ: begin
          state_q   <= WRITE;
          rd_en_q   <= 8'h00;
          wr_en_q   <= dst_oh_q;
          wr_data_q <= bus_rd;
        end
        WRITE: begin
          state_q      <= IDLE;
          wr_en_q      <= 8'h00;
          move_count_q <= move_count_q + 8'd1;
        end
        default: begin
          state_q <= IDLE;
          rd_en_q <= 8'h00;
          wr_en_q <= 8'h00;
        end
      endcase
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign rd_en       = rd_en_q;
  assign wr_en       = wr_en_q;
  assign wr_data     = wr_data_q;
  assign bad_op      = bad_op_q;
  assign move_count  = move_count_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: directed instructions push expected bus
// activity; a negedge monitor pops one entry per active output cycle.
module tb_move_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] bus_rd;
  logic [7:0] rd_en;
  logic [7:0] wr_en;
  logic [7:0] wr_data;
  logic       bad_op;
  logic [7:0] move_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] rd;
    logic [7:0] wr;
    logic [7:0] data;
    logic [7:0] cnt;
    logic       bad;
  } ev_t;

  ev_t        sbq[$];
  logic [7:0] exp_count = 8'h00;

  localparam logic [7:0] REGS [8] = '{8'hA0, 8'hB1, 8'hC2, 8'h5C, 8'hD4, 8'hE5, 8'hF6, 8'h07};

  move_sequencer #(.UUID(0), .NAME("tb")) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .bus_rd      (bus_rd),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .bad_op      (bad_op),
    .move_count  (move_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    bus_rd = 8'h00;
    for (int i = 0; i < 8; i++)
      if (rd_en[i]) bus_rd = REGS[i];
  end

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h (t=%0t)", name, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (rd_en != 8'h00 || wr_en != 8'h00 || bad_op) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output rd_en=%02h wr_en=%02h bad_op=%0b required=none (t=%0t)",
                 rd_en, wr_en, bad_op, $time);
      end else begin
        e = sbq.pop_front();
        check("mon_rd_en", rd_en, e.rd);
        check("mon_wr_en", wr_en, e.wr);
        check("mon_bad_op", {7'd0, bad_op}, {7'd0, e.bad});
        if (e.wr != 8'h00) check("mon_wr_data", wr_data, e.data);
        check("mon_move_count", move_count, e.cnt);
      end
    end
  end

  function automatic void push_copy(input logic [7:0] rd, input logic [7:0] wr, input logic [7:0] data);
    sbq.push_back('{rd: rd, wr: 8'h00, data: 8'h00, cnt: exp_count, bad: 1'b0});
    sbq.push_back('{rd: 8'h00, wr: wr, data: data, cnt: exp_count, bad: 1'b0});
    exp_count = exp_count + 8'd1;
  endfunction

  function automatic void push_imm(input logic [7:0] data);
    sbq.push_back('{rd: 8'h00, wr: 8'h01, data: data, cnt: exp_count, bad: 1'b0});
    exp_count = exp_count + 8'd1;
  endfunction

  function automatic void push_bad();
    sbq.push_back('{rd: 8'h00, wr: 8'h00, data: 8'h00, cnt: exp_count, bad: 1'b1});
  endfunction

  // Returns the index of the edge at which the instruction was accepted.
  task automatic send(input logic [7:0] ins, input logic hold, output int acc_edge);
    int n;
    instr = ins;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc_edge = -1;
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_ready required=ready instr=%02h", ins);
      instr_valid = 1'b0;
    end else begin
      @(posedge clk);
      acc_edge = cyc;
      #1;
      if (!hold) instr_valid = 1'b0;
    end
  endtask

  task automatic wait_ready(output int rdy_edge);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_ready && n < 20);
    rdy_edge = cyc - 1;
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=not_ready required=ready");
    end
  endtask

  initial begin
    int a1, a2, r;
    rst = 1'b0;
    #12;
    check("rst_ready", {7'd0, instr_ready}, 8'h01);
    check("rst_rd_en", rd_en, 8'h00);
    check("rst_wr_en", wr_en, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_bad_op", {7'd0, bad_op}, 8'h00);
    check("rst_move_count", move_count, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    push_copy(8'h08, 8'h04, 8'h5C);
    send(8'h9A, 1'b0, a1);
    wait_ready(r);
    check("copy_latency", 8'(r - a1), 8'd2);
    check("copy_count", move_count, 8'd1);

    push_imm(8'h3F);
    send(8'h3F, 1'b0, a1);
    wait_ready(r);
    check("imm_latency", 8'(r - a1), 8'd1);
    check("imm_count", move_count, 8'd2);

    push_bad();
    send(8'h45, 1'b0, a1);
    @(negedge clk);
    check("bad45_ready", {7'd0, instr_ready}, 8'h01);
    push_bad();
    send(8'hC0, 1'b0, a1);
    @(negedge clk);
    check("badC0_ready", {7'd0, instr_ready}, 8'h01);
    @(negedge clk);
    check("bad_count", move_count, 8'd2);
    check("wr_data_hold", wr_data, 8'h3F);

    push_copy(8'h40, 8'h40, 8'hF6);
    send(8'hB6, 1'b0, a1);
    wait_ready(r);
    check("same_slot_count", move_count, 8'd3);

    push_copy(8'h08, 8'h04, 8'h5C);
    push_copy(8'h02, 8'h01, 8'hB1);
    send(8'h9A, 1'b1, a1);
    send(8'h88, 1'b0, a2);
    check("b2b_accept_gap", 8'(a2 - a1), 8'd3);
    wait_ready(r);
    check("b2b_count", move_count, 8'd5);

    sbq.push_back('{rd: 8'h04, wr: 8'h00, data: 8'h00, cnt: exp_count, bad: 1'b0});
    send(8'h91, 1'b0, a1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_rd_en", rd_en, 8'h00);
    check("abort_wr_en", wr_en, 8'h00);
    check("abort_move_count", move_count, 8'h00);
    check("abort_wr_data", wr_data, 8'h00);
    exp_count = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready_after", {7'd0, instr_ready}, 8'h01);
    repeat (3) @(negedge clk);
    check("abort_no_write", move_count, 8'h00);

    for (int i = 0; i < 256; i++) begin
      logic [7:0] ins;
      ins = {2'b00, 6'(i)};
      push_imm(ins);
      send(ins, 1'b0, a1);
    end
    wait_ready(r);
    check("wrap_count", move_count, 8'h00);

    for (int n = 0; n < 50 && sbq.size() != 0; n++) @(negedge clk);
    check("scoreboard_empty", 8'(sbq.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
